// File: rtl/cfg_self_loader.sv
// rtl/cfg_self_loader.sv - autonomous bitstream loader driving the fabric self-write port
//
// Purpose:
//   Reads a block of 32-bit configuration words from a synchronous on-chip
//   memory and replays each one as a single-cycle SelfWriteStrobe pulse.
//   Every pulse is followed by a fixed idle gap so that the downstream
//   config controller has time to consume the word.
//
// Parameters:
//   AddrWidth      - width of mem_addr, base_addr, word_count, words_written
//   MemReadLatency - cycles from mem_rd to valid mem_rdata (1..4)
//   StrobeGap      - idle cycles forced after every strobe (1..15)
//
// Ports:
//   CLK, reset      - single clock, synchronous active-high reset
//   start, abort    - load request (sampled in IDLE) / terminate active load
//   base_addr       - first memory address, sampled with start
//   word_count      - number of words to send, sampled with start
//   mem_addr/mem_rd - memory read request, non-zero only in FETCH
//   mem_rdata       - memory read data
//   SelfWriteStrobe - one-cycle write pulse to the fabric top
//   SelfWriteData   - config word, held between strobes
//   busy, done      - load in progress / one-cycle completion pulse
//   words_written   - strobes issued in the current or last load
//   checksum        - (CFG_SELF_LOADER_CHECKSUM_EN only) mod-2^32 sum of strobed words
//
// Optional feature macro: CFG_SELF_LOADER_CHECKSUM_EN

module cfg_self_loader #(
  parameter int AddrWidth      = 12,
  parameter int MemReadLatency = 1,
  parameter int StrobeGap      = 3
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [AddrWidth-1:0] base_addr,
  input  logic [AddrWidth-1:0] word_count,
  output logic [AddrWidth-1:0] mem_addr,
  output logic                 mem_rd,
  input  logic [31:0]          mem_rdata,
  output logic                 SelfWriteStrobe,
  output logic [31:0]          SelfWriteData,
  output logic                 busy,
  output logic                 done,
  output logic [AddrWidth-1:0] words_written
`ifdef CFG_SELF_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]          checksum
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    WRITE  = 3'd3,
    GAP    = 3'd4,
    FINISH = 3'd5
  } state_t;

  // Counters are preloaded with (length - 1) and the state exits at zero.
  localparam logic [3:0] WaitLoad = 4'(MemReadLatency - 1);
  localparam logic [3:0] GapLoad  = 4'(StrobeGap - 1);

  state_t               state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [AddrWidth-1:0] remaining_q, remaining_d;
  logic [AddrWidth-1:0] words_q, words_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [31:0]          cap_q, cap_d;    // word captured from memory
  logic [31:0]          data_q, data_d;  // last word actually strobed
  logic                 strobe_fire;
`ifdef CFG_SELF_LOADER_CHECKSUM_EN
  logic [31:0]          sum_q, sum_d;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    words_d     = words_q;
    cnt_d       = cnt_q;
    cap_d       = cap_q;
    data_d      = data_q;
    strobe_fire = 1'b0;
`ifdef CFG_SELF_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    // Abort outranks everything, including a WRITE in the same cycle:
    // no strobe, no count update, and any pending read is dropped.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            words_d = '0;
`ifdef CFG_SELF_LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
            if (word_count != '0) begin
              addr_d      = base_addr;
              remaining_d = word_count;
              state_d     = FETCH;
            end else begin
              state_d = FINISH;
            end
          end
        end
        FETCH: begin
          cnt_d   = WaitLoad;
          state_d = WAIT;
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            cap_d   = mem_rdata;
            state_d = WRITE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        WRITE: begin
          strobe_fire = 1'b1;
          data_d      = cap_q;
          words_d     = words_q + 1'b1;
          addr_d      = addr_q + 1'b1;  // wraps modulo 2^AddrWidth
          remaining_d = remaining_q - 1'b1;
          cnt_d       = GapLoad;
          state_d     = GAP;
`ifdef CFG_SELF_LOADER_CHECKSUM_EN
          sum_d       = sum_q + cap_q;
`endif
        end
        GAP: begin
          if (cnt_q == 4'd0) begin
            state_d = (remaining_q != '0) ? FETCH : FINISH;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        FINISH: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      words_q     <= '0;
      cnt_q       <= '0;
      cap_q       <= '0;
      data_q      <= '0;
`ifdef CFG_SELF_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      words_q     <= words_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      data_q      <= data_d;
`ifdef CFG_SELF_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  // The data output only moves when a strobe actually fires, so the
  // capture in WAIT is invisible downstream until the WRITE cycle.
  always_comb begin
    mem_rd          = (state_q == FETCH);
    mem_addr        = (state_q == FETCH) ? addr_q : '0;
    SelfWriteStrobe = strobe_fire;
    SelfWriteData   = strobe_fire ? cap_q : data_q;
    busy            = (state_q == FETCH) || (state_q == WAIT) ||
                      (state_q == WRITE) || (state_q == GAP);
    done            = (state_q == FINISH) && !abort;
    words_written   = words_q;
  end

`ifdef CFG_SELF_LOADER_CHECKSUM_EN
  assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_cfg_self_loader.sv
// tb/tb_cfg_self_loader.sv - directed self-checking bench for cfg_self_loader

module tb_cfg_self_loader;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp;
  int n_fail;

  logic [31:0] mem [0:4095];

  // DUT A: default parameters
  logic        rst_a, a_start, a_abort;
  logic [11:0] a_base, a_count, a_addr, a_words;
  logic        a_rd, a_stb, a_busy, a_done;
  logic [31:0] a_rdata, a_data, a_pipe;
`ifdef CFG_SELF_LOADER_CHECKSUM_EN
  logic [31:0] a_sum;
`endif

  // DUT B: MemReadLatency=3, StrobeGap=1
  logic        rst_b, b_start, b_abort;
  logic [11:0] b_base, b_count, b_addr, b_words;
  logic        b_rd, b_stb, b_busy, b_done;
  logic [31:0] b_rdata, b_data;
  logic [31:0] b_pipe [0:2];
`ifdef CFG_SELF_LOADER_CHECKSUM_EN
  logic [31:0] b_sum;
`endif

  cfg_self_loader u_dut_a (
    .CLK(clk), .reset(rst_a), .start(a_start), .abort(a_abort),
    .base_addr(a_base), .word_count(a_count),
    .mem_addr(a_addr), .mem_rd(a_rd), .mem_rdata(a_rdata),
    .SelfWriteStrobe(a_stb), .SelfWriteData(a_data),
    .busy(a_busy), .done(a_done), .words_written(a_words)
`ifdef CFG_SELF_LOADER_CHECKSUM_EN
    , .checksum(a_sum)
`endif
  );

  cfg_self_loader #(.AddrWidth(12), .MemReadLatency(3), .StrobeGap(1)) u_dut_b (
    .CLK(clk), .reset(rst_b), .start(b_start), .abort(b_abort),
    .base_addr(b_base), .word_count(b_count),
    .mem_addr(b_addr), .mem_rd(b_rd), .mem_rdata(b_rdata),
    .SelfWriteStrobe(b_stb), .SelfWriteData(b_data),
    .busy(b_busy), .done(b_done), .words_written(b_words)
`ifdef CFG_SELF_LOADER_CHECKSUM_EN
    , .checksum(b_sum)
`endif
  );

  // Synchronous memories with 1- and 3-cycle read latency
  always @(posedge clk) begin
    a_pipe    <= a_rd ? mem[a_addr] : 32'h0;
    b_pipe[0] <= b_rd ? mem[b_addr] : 32'h0;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign a_rdata = a_pipe;
  assign b_rdata = b_pipe[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of DUT A: inputs change at negedge, outputs sampled 1 ns later
  task automatic cyc_a(input logic s, input logic ab, input logic [11:0] b, input logic [11:0] c);
    @(negedge clk);
    a_start = s; a_abort = ab; a_base = b; a_count = c;
    #1;
  endtask

  task automatic cyc_b(input logic s, input logic ab, input logic [11:0] b, input logic [11:0] c,
                       input logic r);
    @(negedge clk);
    b_start = s; b_abort = ab; b_base = b; b_count = c; rst_b = r;
    #1;
  endtask

  typedef struct {
    logic        start;
    logic [11:0] base;
    logic [11:0] cnt;
    logic        rd;
    logic [11:0] addr;
    logic        stb;
    logic [31:0] data;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl [0:20];

  int          stb_n, rd_n, done_n, done_cyc, busy_n, last_stb;
  logic [11:0] rd_addr [0:3];
  logic [31:0] stb_data [0:3];
  int          stb_cyc [0:3];

  initial begin
    n_cmp = 0; n_fail = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[12'h010] = 32'hAAAA0001; mem[12'h011] = 32'hAAAA0002; mem[12'h012] = 32'hAAAA0003;
    mem[12'hFFF] = 32'hBBBB0FFF; mem[12'h000] = 32'hBBBB0000;
    for (int i = 0; i < 4; i++) mem[12'h020 + i] = 32'hCCCC0000 + i;
    for (int i = 0; i < 5; i++) mem[12'h100 + i] = 32'hDDDD0000 + i;

    // Expected waveform of the 3-word load from 0x010
    for (int c = 0; c <= 20; c++) begin
      tbl[c].start = (c == 0);
      tbl[c].base  = 12'h010;
      tbl[c].cnt   = 12'd3;
      tbl[c].rd    = (c == 1) || (c == 7) || (c == 13);
      tbl[c].addr  = (c == 1) ? 12'h010 : (c == 7) ? 12'h011 : (c == 13) ? 12'h012 : 12'h000;
      tbl[c].stb   = (c == 3) || (c == 9) || (c == 15);
      tbl[c].data  = (c < 3) ? 32'h0 : (c < 9) ? 32'hAAAA0001 :
                     (c < 15) ? 32'hAAAA0002 : 32'hAAAA0003;
      tbl[c].busy  = (c >= 1) && (c <= 18);
      tbl[c].done  = (c == 19);
    end

    rst_a = 1'b1; a_start = 0; a_abort = 0; a_base = 0; a_count = 0;
    rst_b = 1'b1; b_start = 0; b_abort = 0; b_base = 0; b_count = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset a_rd",    {31'h0, a_rd}, 32'h0);
    check("reset a_addr",  {20'h0, a_addr}, 32'h0);
    check("reset a_stb",   {31'h0, a_stb}, 32'h0);
    check("reset a_data",  a_data, 32'h0);
    check("reset a_busy",  {31'h0, a_busy}, 32'h0);
    check("reset a_done",  {31'h0, a_done}, 32'h0);
    check("reset a_words", {20'h0, a_words}, 32'h0);
    check("reset b_busy",  {31'h0, b_busy}, 32'h0);
    @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;

    // Table-driven basic load
    for (int c = 0; c <= 20; c++) begin
      cyc_a(tbl[c].start, 1'b0, tbl[c].base, tbl[c].cnt);
      check($sformatf("t1[%0d] mem_rd", c),   {31'h0, a_rd},   {31'h0, tbl[c].rd});
      check($sformatf("t1[%0d] mem_addr", c), {20'h0, a_addr}, {20'h0, tbl[c].addr});
      check($sformatf("t1[%0d] strobe", c),   {31'h0, a_stb},  {31'h0, tbl[c].stb});
      check($sformatf("t1[%0d] data", c),     a_data,          tbl[c].data);
      check($sformatf("t1[%0d] busy", c),     {31'h0, a_busy}, {31'h0, tbl[c].busy});
      check($sformatf("t1[%0d] done", c),     {31'h0, a_done}, {31'h0, tbl[c].done});
    end
    check("t1 words_written", {20'h0, a_words}, 32'd3);
`ifdef CFG_SELF_LOADER_CHECKSUM_EN
    check("t1 checksum", a_sum, 32'hFFFE0006);
`endif

    // Zero-length load
    cyc_a(1'b1, 1'b0, 12'h050, 12'd0);
    check("t2 c0 done", {31'h0, a_done}, 32'h0);
    done_n = 0; done_cyc = -1; rd_n = 0; stb_n = 0; busy_n = 0;
    for (int i = 1; i <= 5; i++) begin
      cyc_a(1'b0, 1'b0, 12'h0, 12'h0);
      if (a_done) begin done_n++; done_cyc = i; end
      if (a_rd) rd_n++;
      if (a_stb) stb_n++;
      if (a_busy) busy_n++;
    end
    check("t2 done pulses", done_n, 1);
    check("t2 done cycle", done_cyc, 1);
    check("t2 mem_rd count", rd_n, 0);
    check("t2 strobe count", stb_n, 0);
    check("t2 busy cycles", busy_n, 0);

    // Address wrap-around
    cyc_a(1'b1, 1'b0, 12'hFFF, 12'd2);
    rd_n = 0; stb_n = 0; done_n = 0;
    for (int i = 1; i <= 40 && done_n == 0; i++) begin
      cyc_a(1'b0, 1'b0, 12'h0, 12'h0);
      if (a_rd) begin if (rd_n < 4) rd_addr[rd_n] = a_addr; rd_n++; end
      if (a_stb) begin if (stb_n < 4) stb_data[stb_n] = a_data; stb_n++; end
      if (a_done) done_n++;
    end
    check("t3 done seen", done_n, 1);
    check("t3 mem_rd count", rd_n, 2);
    check("t3 strobe count", stb_n, 2);
    if (rd_n >= 2) begin
      check("t3 addr0", {20'h0, rd_addr[0]}, 32'h00000FFF);
      check("t3 addr1", {20'h0, rd_addr[1]}, 32'h00000000);
    end
    if (stb_n >= 2) begin
      check("t3 data0", stb_data[0], 32'hBBBB0FFF);
      check("t3 data1", stb_data[1], 32'hBBBB0000);
    end
    check("t3 words_written", {20'h0, a_words}, 32'd2);

    // Abort colliding with the second WRITE of a 4-word load (cycle 9)
    cyc_a(1'b1, 1'b0, 12'h020, 12'd4);
    stb_n = 0; done_n = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc_a(1'b0, 1'b0, 12'h0, 12'h0);
      if (a_stb) stb_n++;
    end
    check("t4 strobes before abort", stb_n, 1);
    cyc_a(1'b0, 1'b1, 12'h0, 12'h0);
    check("t4 strobe suppressed", {31'h0, a_stb}, 32'h0);
    if (a_stb) stb_n++;
    cyc_a(1'b0, 1'b0, 12'h0, 12'h0);
    check("t4 busy after abort", {31'h0, a_busy}, 32'h0);
    for (int i = 0; i < 30; i++) begin
      if (a_stb) stb_n++;
      if (a_done) done_n++;
      cyc_a(1'b0, 1'b0, 12'h0, 12'h0);
    end
    check("t4 total strobes", stb_n, 1);
    check("t4 done pulses", done_n, 0);
    check("t4 words_written", {20'h0, a_words}, 32'd1);

    // Second start during a load is ignored
    cyc_a(1'b1, 1'b0, 12'h010, 12'd3);
    stb_n = 0; done_cyc = -1;
    for (int i = 1; i <= 25; i++) begin
      if (i == 4) cyc_a(1'b1, 1'b0, 12'h100, 12'd5);
      else        cyc_a(1'b0, 1'b0, 12'h0, 12'h0);
      if (a_stb) begin if (stb_n < 4) stb_data[stb_n] = a_data; stb_n++; end
      if (a_done && done_cyc < 0) done_cyc = i;
    end
    check("t5 strobe count", stb_n, 3);
    check("t5 done cycle", done_cyc, 19);
    if (stb_n >= 3) begin
      check("t5 data0", stb_data[0], 32'hAAAA0001);
      check("t5 data1", stb_data[1], 32'hAAAA0002);
      check("t5 data2", stb_data[2], 32'hAAAA0003);
    end
    check("t5 words_written", {20'h0, a_words}, 32'd3);

    // Latency 3, gap 1: word period 6
    cyc_b(1'b1, 1'b0, 12'h010, 12'd2, 1'b0);
    stb_n = 0; done_cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      cyc_b(1'b0, 1'b0, 12'h0, 12'h0, 1'b0);
      if (b_stb) begin
        if (stb_n < 4) begin stb_cyc[stb_n] = i; stb_data[stb_n] = b_data; end
        stb_n++;
      end
      if (b_done && done_cyc < 0) done_cyc = i;
    end
    check("t6 strobe count", stb_n, 2);
    if (stb_n >= 2) begin
      check("t6 first strobe cycle", stb_cyc[0], 5);
      check("t6 strobe spacing", stb_cyc[1] - stb_cyc[0], 6);
      check("t6 data0", stb_data[0], 32'hAAAA0001);
      check("t6 data1", stb_data[1], 32'hAAAA0002);
    end
    check("t6 done cycle", done_cyc, 13);

    // Reset between strobes of a 3-word load
    cyc_b(1'b1, 1'b0, 12'h010, 12'd3, 1'b0);
    stb_n = 0; last_stb = 0;
    for (int i = 1; i <= 6; i++) begin
      cyc_b(1'b0, 1'b0, 12'h0, 12'h0, 1'b0);
      if (b_stb) stb_n++;
    end
    check("t6r strobe before reset", stb_n, 1);
    cyc_b(1'b0, 1'b0, 12'h0, 12'h0, 1'b1);
    cyc_b(1'b0, 1'b0, 12'h0, 12'h0, 1'b1);
    stb_n = 0; busy_n = 0; done_n = 0;
    for (int i = 0; i < 30; i++) begin
      cyc_b(1'b0, 1'b0, 12'h0, 12'h0, 1'b0);
      if (b_stb) stb_n++;
      if (b_busy) busy_n++;
      if (b_done) done_n++;
      if (b_rd) last_stb++;
    end
    check("t6r strobes after reset", stb_n, 0);
    check("t6r busy after reset", busy_n, 0);
    check("t6r done after reset", done_n, 0);
    check("t6r mem_rd after reset", last_stb, 0);
    check("t6r data", b_data, 32'h0);
    check("t6r addr", {20'h0, b_addr}, 32'h0);
    check("t6r words_written", {20'h0, b_words}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
